// File: rtl/ckt2_sweep_ctrl_pkg.sv
// Shared types and constants for the ckt2 truth-table sweep controller.
package ckt2_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StCapture,
    StDone
  } state_e;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned TBL_W   = 16;

endpackage

// File: rtl/tt_vec_cnt.sv
// Vector index and settle counter for the sweep; flags the final vector and the
// last settle cycle of the current vector.
module tt_vec_cnt
  import ckt2_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SettleCyc = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       settle_en_i,
  input  logic       adv_i,
  output logic [2:0] idx_o,
  output logic       last_vec_o,
  output logic       settle_done_o
);

  logic [2:0] idx_q;
  logic [1:0] settle_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || load_i) begin
      idx_q    <= 3'd0;
      settle_q <= 2'd0;
    end else if (adv_i) begin
      idx_q    <= idx_q + 3'd1;
      settle_q <= 2'd0;
    end else if (settle_en_i) begin
      settle_q <= settle_q + 2'd1;
    end
  end

  assign idx_o         = idx_q;
  assign last_vec_o    = (idx_q == 3'(NUM_VEC - 1));
  assign settle_done_o = (settle_q == 2'(SettleCyc - 1));

endmodule

// File: rtl/ckt2_sweep_ctrl.sv
// Walks the 8 input vectors of ckt2, captures {f1,f2} per vector and compares
// against an expected table, reporting mismatches and a pass flag.
module ckt2_sweep_ctrl
  import ckt2_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [TBL_W-1:0] exp_tbl,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             f1,
  input  logic             f2,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] result,
  output logic [3:0]       mismatch_cnt,
  output logic             pass
);

  state_e           state_q, state_d;
  logic [2:0]       idx, idx_nxt, xyz_q;
  logic             busy_q, done_q;
  logic [TBL_W-1:0] result_q, result_d;
  logic [3:0]       mism_q, mism_d;
  logic             pass_q, pass_d;
  logic             cnt_load, settle_en, cnt_adv, last_vec, settle_done;
  logic [3:0]       bit_sel;

  tt_vec_cnt #(
    .SettleCyc(SETTLE_CYC)
  ) u_vec_cnt (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (cnt_load),
    .settle_en_i  (settle_en),
    .adv_i        (cnt_adv),
    .idx_o        (idx),
    .last_vec_o   (last_vec),
    .settle_done_o(settle_done)
  );

  assign bit_sel = {idx, 1'b0};

  always_comb begin
    state_d   = state_q;
    idx_nxt   = idx;
    cnt_load  = 1'b0;
    settle_en = 1'b0;
    cnt_adv   = 1'b0;
    result_d  = result_q;
    mism_d    = mism_q;
    pass_d    = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StApply;
          idx_nxt  = 3'd0;
          cnt_load = 1'b1;
          result_d = '0;
          mism_d   = 4'd0;
          pass_d   = 1'b0;
        end
      end
      StApply: begin
        if (abort) begin
          state_d  = StIdle;
          idx_nxt  = 3'd0;
          cnt_load = 1'b1;
        end else if (settle_done) begin
          state_d = StCapture;
        end else begin
          settle_en = 1'b1;
        end
      end
      StCapture: begin
        // Abort wins: the current vector is neither recorded nor counted.
        if (abort) begin
          state_d  = StIdle;
          idx_nxt  = 3'd0;
          cnt_load = 1'b1;
        end else begin
          result_d[bit_sel +: 2] = {f1, f2};
          if ({f1, f2} != exp_tbl[bit_sel +: 2]) begin
            mism_d = mism_q + 4'd1;
          end
          if (last_vec) begin
            state_d = StDone;
            pass_d  = (mism_d == 4'd0);
          end else begin
            state_d = StApply;
            idx_nxt = idx + 3'd1;
            cnt_adv = 1'b1;
          end
        end
      end
      StDone: begin
        state_d  = StIdle;
        idx_nxt  = 3'd0;
        cnt_load = 1'b1;
      end
      default: begin
        state_d  = StIdle;
        cnt_load = 1'b1;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      xyz_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mism_q   <= 4'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xyz_q    <= (state_d == StApply || state_d == StCapture) ? idx_nxt : 3'd0;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
      result_q <= result_d;
      mism_q   <= mism_d;
      pass_q   <= pass_d;
    end
  end

  assign {x, y, z}    = xyz_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign mismatch_cnt = mism_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_ckt2_sweep_ctrl.sv
// Directed bench for ckt2_sweep_ctrl with a behavioural ckt2 model
// (f1 = x^y^z, f2 = x&y), whose full truth table packs to 16'hD228.
module tb_ckt2_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] exp_tbl;
  logic        x, y, z, f1, f2;
  logic        busy, done, pass;
  logic [15:0] result;
  logic [3:0]  mismatch_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign f1 = x ^ y ^ z;
  assign f2 = x & y;

  ckt2_sweep_ctrl #(
    .SETTLE_CYC(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .exp_tbl     (exp_tbl),
    .x           (x),
    .y           (y),
    .z           (z),
    .f1          (f1),
    .f2          (f2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mismatch_cnt(mismatch_cnt),
    .pass        (pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full sweep. The start-sampling edge is edge 1; done must be seen after edge 17.
  // With poke_start, start is re-pulsed mid-sweep and during DONE and must be ignored.
  task automatic sweep(input string tag, input logic [15:0] tbl, input logic [15:0] exp_res,
                       input logic [3:0] exp_mm, input logic exp_pass, input bit poke_start);
    int lat;
    bit seen;
    exp_tbl = tbl;
    start   = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    seen  = 1'b0;
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, " cleared_pass"}, 32'(pass), 32'd0);
    while (!seen && lat < 40) begin
      if (poke_start && (lat == 6 || lat == 16)) start = 1'b1;
      step();
      start = 1'b0;
      lat++;
      if (done) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(lat), 32'd17);
    chk({tag, " result"}, 32'(result), 32'(exp_res));
    chk({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'(exp_mm));
    chk({tag, " pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
    chk({tag, " xyz_in_done"}, 32'({x, y, z}), 32'd0);
    start = poke_start;
    step();
    start = 1'b0;
    chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, " busy_after_done"}, 32'(busy), 32'd0);
    chk({tag, " result_hold"}, 32'(result), 32'(exp_res));
    chk({tag, " pass_hold"}, 32'(pass), 32'(exp_pass));
  endtask

  initial begin
    int done_cnt;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    exp_tbl = 16'h0000;
    step();
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset xyz", 32'({x, y, z}), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    chk("reset pass", 32'(pass), 32'd0);
    rst_n = 1'b1;
    step();

    sweep("match", 16'hD228, 16'hD228, 4'd0, 1'b1, 1'b0);

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort busy", 32'(busy), 32'd0);
    chk("idle_abort result", 32'(result), 32'hD228);
    chk("idle_abort pass", 32'(pass), 32'd1);

    sweep("one_miss", 16'hD229, 16'hD228, 4'd1, 1'b0, 1'b0);
    sweep("all_miss", 16'h2DD7, 16'hD228, 4'd8, 1'b0, 1'b0);

    // Abort during APPLY of vector 2: vectors 0 and 1 already captured.
    exp_tbl = 16'hD228;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_abort xyz", 32'({x, y, z}), 32'd2);
    chk("pre_abort busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort xyz", 32'({x, y, z}), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort partial result", 32'(result), 32'h0008);
    chk("abort mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    chk("abort pass", 32'(pass), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("abort no done pulse", 32'(done_cnt), 32'd0);

    sweep("start_while_busy", 16'hD228, 16'hD228, 4'd0, 1'b1, 1'b1);

    // Reset at cycle 7 of an all-mismatch sweep: three vectors counted so far.
    exp_tbl = 16'h2DD7;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("pre_reset mismatch_cnt", 32'(mismatch_cnt), 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset xyz", 32'({x, y, z}), 32'd0);
    chk("midreset result", 32'(result), 32'd0);
    chk("midreset mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    chk("midreset pass", 32'(pass), 32'd0);

    sweep("after_reset", 16'hD228, 16'hD228, 4'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ckt2_sweep_ctrl.md
CKT2_SWEEP_CTRL -- requirements
Module: ckt2_sweep_ctrl

Interface
REQ-001 The block SHALL have exactly one parameter, SETTLE_CYC, default 1, range 1..3: the number of APPLY cycles per vector before capture.
REQ-002 The block SHALL have one clock and reset SHALL be synchronous and active-low.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: start  input  1  request a full 8-vector sweep; honoured only in IDLE.
REQ-006 Port: abort  input  1  cancel a sweep in progress.
REQ-007 Port: exp_tbl  input  16  expected table; bits [2i+1:2i] = {F1,F2} expected for vector i.
REQ-008 Port: x, y, z  output  1 each  registered stimulus to the ckt2 datapath; {x,y,z} = vector index i, x is the MSB.
REQ-009 Port: f1, f2  input  1 each  ckt2 outputs, sampled by the block.
REQ-010 Port: busy  output  1  high in APPLY, CAPTURE and DONE.
REQ-011 Port: done  output  1  one-cycle pulse at sweep completion.
REQ-012 Port: result  output  16  captured table, same packing as exp_tbl.
REQ-013 Port: mismatch_cnt  output  4  number of vectors whose {f1,f2} differ from exp_tbl (0..8).
REQ-014 Port: pass  output  1  high when the last completed sweep had mismatch_cnt == 0.

Function
REQ-015 The FSM SHALL have four states (IDLE, APPLY, CAPTURE, DONE), a 3-bit vector index idx and a 2-bit settle counter.
REQ-016 In IDLE, start=1 SHALL have the following effects at the next edge: go to APPLY, set idx=0, clear result, clear mismatch_cnt and clear pass.
REQ-017 x,y,z SHALL equal idx in APPLY and CAPTURE, and SHALL be 0 in IDLE and DONE.
REQ-018 APPLY SHALL last exactly SETTLE_CYC cycles and then go to CAPTURE.
REQ-019 CAPTURE SHALL last one cycle and perform the following updates:
  - write result[2*idx+1:2*idx] = {f1,f2};
  - increment mismatch_cnt if {f1,f2} != exp_tbl[2*idx+1:2*idx].
REQ-020 After CAPTURE, if idx == 7 the FSM SHALL go to DONE; otherwise it SHALL set idx = idx+1 and go to APPLY. idx SHALL never wrap in-sweep.
REQ-021 DONE SHALL last one cycle, with done=1 and pass set to (final mismatch_cnt == 0); the FSM SHALL then return to IDLE.
REQ-022 Latency SHALL be 8*(SETTLE_CYC+1)+1 cycles from the start-sampling edge to the done-high cycle; this is 17 cycles for SETTLE_CYC=1.
REQ-023 start outside IDLE, including during DONE, SHALL be ignored.
REQ-024 abort in APPLY or CAPTURE SHALL return the FSM to IDLE at the next edge, with the following effects:
  - no done pulse;
  - pass stays 0;
  - result and mismatch_cnt hold their partial values;
  - abort has priority over the CAPTURE write in the same cycle.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 result, mismatch_cnt and pass SHALL hold in IDLE until the next accepted start.
REQ-027 exp_tbl SHALL be sampled only in CAPTURE; changes to it mid-sweep affect only vectors not yet captured.

Reset
REQ-028 rst_n=0 at an edge SHALL force the following values, regardless of state, including mid-sweep:
  - state=IDLE, idx=0, settle counter=0;
  - x=y=z=0, busy=0, done=0;
  - result=0, mismatch_cnt=0, pass=0.
REQ-029 Reset SHALL take priority over start and abort.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, APPLY, CAPTURE, DONE), NUM_VEC=8, and the result/exp_tbl width constant 16.
REQ-031 One sub-module SHALL be used: tt_vec_cnt, the idx/settle counter with load, enable and last-vector flag.
REQ-032 ckt2 SHALL be instantiated at integration level, not inside this block.

Verification
REQ-033 Bench model: f1 = x^y^z and f2 = x&y, driven combinationally from x,y,z; SETTLE_CYC=1.
REQ-034 Scenario: start with exp_tbl=16'hD228 -> result=16'hD228, mismatch_cnt=0, pass=1, done high exactly 17 cycles after the start edge, busy low the next cycle.
REQ-035 Scenario: exp_tbl=16'hD229 -> result=16'hD228, mismatch_cnt=1, pass=0.
REQ-036 Scenario: exp_tbl=16'h2DD7 -> mismatch_cnt=8, pass=0, no counter overflow.
REQ-037 Scenario: abort asserted 5 cycles after start -> IDLE next edge, x=y=z=0, busy=0, no done pulse; start pulsed while busy during a sweep -> sweep timing unchanged.
REQ-038 Scenario: rst_n=0 for one cycle at cycle 7 of a sweep -> all outputs 0 next edge; a new start then completes with pass=1 for exp_tbl=16'hD228.
